// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding, owner codes and memory geometry
package mem_port_arbiter_pkg;
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// arb_wait_counter: saturating count of arbitrations lost by a pending loader request
module arb_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  // clear wins over increment; stop counting once the forced-win threshold is reached
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 1'b1;
  assign at_max = cnt == CW'(MAX_WAIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM port between the CPU and the loader
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          locked
);
  state_t        state;
  logic          at_max;
  logic          idle;
  logic          ldr_win;
  logic          cpu_win;
  logic [DW-1:0] cpu_rq;
  logic [DW-1:0] ldr_rq;
  assign idle    = state == IDLE;
  assign ldr_win = idle && ldr_req && (ldr_lock || at_max || !cpu_req);
  assign cpu_win = idle && cpu_req && !ldr_lock && !ldr_win;
  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clock (clock),
    .reset (reset),
    .inc   (cpu_win && ldr_req),
    .clr   (ldr_win || !ldr_req),
    .at_max(at_max)
  );
  // arbitrate in IDLE, drive the RAM for one cycle, then report read data
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= OWN_CPU;
      locked     <= 1'b0;
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      cpu_rq     <= '0;
      ldr_rq     <= '0;
    end else begin
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          locked <= ldr_lock;
          if (cpu_win || ldr_win) begin
            state     <= ACCESS;
            mem_en    <= 1'b1;
            mem_we    <= ldr_win ? ldr_we : cpu_we;
            mem_addr  <= ldr_win ? ldr_addr : cpu_addr;
            mem_wdata <= ldr_win ? ldr_wdata : cpu_wdata;
            owner     <= ldr_win ? OWN_LDR : OWN_CPU;
            cpu_gnt   <= cpu_win;
            ldr_gnt   <= ldr_win;
          end
        end
        ACCESS: begin
          state      <= RESP;
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          cpu_rvalid <= !mem_we && owner == OWN_CPU;
          ldr_rvalid <= !mem_we && owner == OWN_LDR;
        end
        RESP: begin
          state <= IDLE;
          if (cpu_rvalid) cpu_rq <= mem_rdata;
          if (ldr_rvalid) ldr_rq <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  assign cpu_stall = locked;
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rq;
  assign ldr_rdata = ldr_rvalid ? mem_rdata : ldr_rq;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port program/data RAM between two requesters: the CPU datapath (instruction fetch and load/store/add/sub operands) and a program-loader/debug port driven from board switches.
- Sits between both requesters and the RAM.
- Enforces a three-phase access sequence: arbitrate, access, respond.
- Uses fixed CPU priority with a starvation guard, and supports a loader lock that stalls the CPU during bulk program loading.

Parameters:
- AW, 5, RAM address width (32 words).
- DW, 8, RAM data width.
- MAX_WAIT, 4, number of consecutive arbitrations a pending loader request may lose before it is forced to win (1..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU access being performed.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid (reads only).
- cpu_rdata  out  DW  registered CPU read data; holds until the next CPU read.
- cpu_stall  out  1  high while the loader lock is active.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/AW/DW  loader request, same rules as the CPU signals.
- ldr_lock  in  1  loader requests exclusive ownership.
- ldr_gnt, ldr_rvalid  out  1  loader grant pulse and read-valid pulse.
- ldr_rdata  out  DW  registered loader read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; synchronous, valid the cycle after mem_en.
- owner  out  1  0 = CPU, 1 = loader; owner of the current or last access.
- locked  out  1  lock mode active.

Behaviour:
- Reset: when reset is asserted (low), the block resets asynchronously.
  - State goes to IDLE.
  - All outputs go to 0, including rdata registers, owner, locked, cpu_stall.
  - The wait counter clears to 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: sample the requests and ldr_lock at the clock edge.
  - locked <= ldr_lock. The lock only changes in IDLE, never mid-access.
  - Winner selection:
    - if locked: loader, if ldr_req is high;
    - else if ldr_req and wait_cnt == MAX_WAIT: loader;
    - else if cpu_req: CPU;
    - else if ldr_req: loader;
    - else stay in IDLE.
  - On a winner: latch that port's we, addr and wdata into the mem_* registers, set owner, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_en = 1; mem_we = the latched we.
  - The winner's gnt pulses for this cycle.
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - mem_en = 0.
  - If the access was a read: the winner's rdata <= mem_rdata and its rvalid pulses.
  - Next state is IDLE.
- Latency and throughput:
  - Request seen in IDLE at edge T → gnt during cycle T+1 → rvalid during cycle T+2.
  - Maximum throughput is one access per 3 cycles.
- Requester rules:
  - A requester may drop req in its gnt cycle.
  - If req stays high after gnt, it is treated as a new request at the next IDLE.
  - Changing we/addr/wdata while req is high and before gnt is illegal; the latched values are those sampled at the winning IDLE edge.
- Wait counter:
  - Increments, saturating at MAX_WAIT, at each IDLE arbitration where ldr_req = 1 and the CPU wins.
  - Clears on a loader grant or whenever ldr_req = 0.
- Lock:
  - cpu_stall = locked.
  - While locked, the CPU is never granted, even if ldr_req is low.
  - When ldr_lock drops, it takes effect at the next IDLE edge, and the CPU may win in that same arbitration.
- Simultaneous events:
  - If both requests arrive in the same IDLE cycle with wait_cnt < MAX_WAIT, the CPU wins.
  - When a lock is raised while the CPU holds a request, the in-flight access completes and the CPU request then waits.
- Reset mid-operation:
  - mem_en and mem_we drop immediately.
  - A write in ACCESS is not committed if reset is asserted before the clock edge.
  - No rvalid is issued afterwards.
- Width rules:
  - Addresses pass through unchanged, with no wrap arithmetic; address 31 is a valid access.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10;
  - owner constants: OWN_CPU = 0, OWN_LDR = 1;
  - default AW/DW values shared with the processor memory.
- One sub-module, arb_wait_counter: saturating starvation counter with inc and clr inputs and an at_max output, parameterised by MAX_WAIT.

Test Plan:
- CPU read: RAM[5] = 0x2A; cpu_req with addr 5 at edge T → cpu_gnt, mem_en = 1 and mem_addr = 5 in T+1; cpu_rvalid = 1 and cpu_rdata = 0x2A in T+2; the loader sees no pulses.
- Contention, MAX_WAIT = 3: cpu_req held high continuously, ldr_req held high → CPU wins 3 arbitrations, the loader is granted on the 4th, and wait_cnt returns to 0.
- Cross-port coherence: loader writes 0x7F to addr 10, then the CPU reads addr 10 → cpu_rdata = 0x7F; ldr_rvalid never pulses for the write.
- Lock bulk load: ldr_lock = 1, loader writes RAM[i] = i for i = 0..31 while cpu_req is held → cpu_gnt stays 0 and cpu_stall = 1 throughout; readback shows all 32 words correct; after ldr_lock drops, cpu_gnt pulses within 2 cycles.
- Reset mid-write: RAM[3] = 0x00; reset asserted during ACCESS of a write of 0x55 to addr 3 → mem_en and mem_we = 0 immediately, all outputs 0; after release the state is IDLE and RAM[3] is still 0x00.
- Back-to-back same requester: cpu_req held high for 3 reads (addrs 1, 2, 3) → gnt pulses exactly 3 cycles apart, and each rvalid carries the matching data.
